dmem_responder: RTL and testbench

//   Memory-side responder for CPU load/store traffic. It accepts one word request at a

---
 rtl/dmem_responder_if.sv | 20 ++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bus between a CPU load/store unit and the data memory
// responder. The master drives a request; the slave answers with ack and rdata.
interface dmem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              err;

  modport master (output req, output we, output addr, output wdata,
                  input  ack, input  rdata, input  busy, input  err);
  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output ack, output rdata, output busy, output err);
endinterface

// File: rtl/dmem_responder.sv
// Data memory responder: one word request in flight, WAIT_CYCLES wait states
// between accept and a one-cycle ack. The memory array is never reset.
// Optional feature macro: DMEM_RESP_ERR_EN -- out-of-range accesses complete
// with err=1 and have no effect; otherwise addresses wrap modulo DEPTH.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              eff_we;
  logic [IDX_W-1:0]  eff_idx;
  logic [DATA_W-1:0] eff_wdata;
  logic              blocked;

  assign accept = (state == S_IDLE) && bus.req;

  // With zero wait states the commit happens on the accept edge itself, so the
  // live bus fields are used there; otherwise the captured copies are used.
  always_comb begin
    enter_resp = 1'b0;
    eff_we     = we_q;
    eff_idx    = idx_q;
    eff_wdata  = wdata_q;
    if (state == S_IDLE) begin
      enter_resp = accept && (WAIT_CYCLES == 0);
      eff_we     = bus.we;
      eff_idx    = bus.addr[IDX_W-1:0];
      eff_wdata  = bus.wdata;
    end else if (state == S_WAIT) begin
      enter_resp = (cnt == 4'd0);
    end
  end

`ifdef DMEM_RESP_ERR_EN
  logic oor_q;
  logic eff_oor;
  logic err_q;

  assign eff_oor = (state == S_IDLE) ? (|(bus.addr >> IDX_W)) : oor_q;
  assign blocked = eff_oor;

  // Out-of-range flag travels with the request; err is set only in the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) oor_q <= |(bus.addr >> IDX_W);
      err_q <= enter_resp && eff_oor;
    end
  end
  assign bus.err = err_q;
`else
  logic unused_upper_addr;
  assign unused_upper_addr = ^bus.addr;
  assign blocked = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Control FSM plus request capture and load data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            idx_q   <= bus.addr[IDX_W-1:0];
            wdata_q <= bus.wdata;
            cnt     <= WAIT_LOAD;
            state   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (enter_resp && !eff_we && !blocked) rdata_q <= mem[eff_idx];
    end
  end

  // Store commit into the array on the edge entering RESP; no reset on contents.
  always_ff @(posedge clk) begin
    if (enter_resp && eff_we && !blocked && rst_n) mem[eff_idx] <= eff_wdata;
  end

  assign bus.ack   = (state == S_RESP);
  assign bus.busy  = (state != S_IDLE);
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: DUT 0 with two wait states, DUT 1 with none.
// Expected ack results are queued per DUT at drive time and checked on ack.
module tb_dmem_responder;
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_v   [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        ack_v   [2];
  logic        busy_v  [2];
  logic        err_v   [2];
  logic [31:0] rdata_v [2];

  dmem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
  dmem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();

  assign bus_a.req = req_v[0];  assign bus_a.we = we_v[0];
  assign bus_a.addr = addr_v[0]; assign bus_a.wdata = wdata_v[0];
  assign bus_b.req = req_v[1];  assign bus_b.we = we_v[1];
  assign bus_b.addr = addr_v[1]; assign bus_b.wdata = wdata_v[1];
  assign ack_v[0] = bus_a.ack;  assign busy_v[0] = bus_a.busy;
  assign err_v[0] = bus_a.err;  assign rdata_v[0] = bus_a.rdata;
  assign ack_v[1] = bus_b.ack;  assign busy_v[1] = bus_b.busy;
  assign err_v[1] = bus_b.err;  assign rdata_v[1] = bus_b.rdata;

  dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(2))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

`ifdef DMEM_RESP_ERR_EN
  localparam bit ERR_MODE = 1'b1;
`else
  localparam bit ERR_MODE = 1'b0;
`endif

  int n_vec = 0;
  int n_mis = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] model [2][256];
  logic [31:0] last_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: compute the ack-time outcome of one request and queue it.
  task automatic push_exp(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic [7:0] idx;
    logic oor;
    idx = a[7:0];
    oor = |a[31:8];
    e.err = 1'b0;
    if (ERR_MODE && oor) begin
      e.err = 1'b1;
      e.rdata = last_rd[k];
    end else if (w) begin
      model[k][idx] = d;
      e.rdata = last_rd[k];
    end else begin
      e.rdata = model[k][idx];
      last_rd[k] = e.rdata;
    end
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // One full transaction with latency and busy checks; mutate scribbles on the
  // bus during the wait phase to show captured fields are what matter.
  task automatic xact(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input bit mutate);
    int cyc;
    int lat;
    lat = (k == 0) ? 2 : 0;
    push_exp(k, w, a, d);
    @(negedge clk);
    req_v[k] = 1'b1; we_v[k] = w; addr_v[k] = a; wdata_v[k] = d;
    @(posedge clk); #1;
    req_v[k] = 1'b0;
    cyc = 0;
    while (ack_v[k] !== 1'b1 && cyc < 20) begin
      chk("busy_wait", 32'(busy_v[k]), 32'd1);
      if (mutate) begin
        req_v[k] = 1'b1; addr_v[k] = 32'd9; wdata_v[k] = 32'hBAD0BAD0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_v[k] = 1'b0;
    chk("ack_latency", 32'(cyc), 32'(lat));
    chk("busy_at_ack", 32'(busy_v[k]), 32'd1);
    @(posedge clk); #1;
    chk("ack_pulse_end", 32'(ack_v[k]), 32'd0);
    chk("busy_end", 32'(busy_v[k]), 32'd0);
  endtask

  // Scoreboard: every ack pops one expectation; err must stay low without ack.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (ack_v[k] === 1'b1) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            chk("spurious_ack", 32'd1, 32'd0);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("ack_rdata", rdata_v[k], e.rdata);
            chk("ack_err", 32'(err_v[k]), 32'(e.err));
          end
        end else begin
          chk("err_no_ack", 32'(err_v[k]), 32'd0);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 1'b0; we_v[k] = 1'b0; addr_v[k] = '0; wdata_v[k] = '0;
      last_rd[k] = '0;
    end

    // Reset values while asserted and after release.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ack", 32'(ack_v[k]), 32'd0);
      chk("rst_busy", 32'(busy_v[k]), 32'd0);
      chk("rst_rdata", rdata_v[k], 32'd0);
      chk("rst_err", 32'(err_v[k]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_ack", 32'(ack_v[k]), 32'd0);
      chk("post_rst_busy", 32'(busy_v[k]), 32'd0);
      chk("post_rst_rdata", rdata_v[k], 32'd0);
    end

    // Known background values for the words later tests inspect.
    xact(0, 1'b1, 32'd3, 32'h3333_3333, 1'b0);
    xact(0, 1'b1, 32'd7, 32'h7777_7777, 1'b0);
    xact(0, 1'b1, 32'd9, 32'h9999_9999, 1'b0);
    xact(1, 1'b1, 32'd1, 32'h1111_1111, 1'b0);

    // Store then load with two wait states.
    xact(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0);
    xact(0, 1'b0, 32'd5, 32'h0, 1'b0);
    chk("load5_rdata", rdata_v[0], 32'hDEADBEEF);

    // Zero wait states, req held high through ack: two back-to-back accepts.
    push_exp(1, 1'b0, 32'd1, 32'h0);
    push_exp(1, 1'b0, 32'd1, 32'h0);
    @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'd1;
    @(posedge clk); #1;
    chk("w0_ack_first", 32'(ack_v[1]), 32'd1);
    @(posedge clk); #1;
    chk("w0_idle_gap_ack", 32'(ack_v[1]), 32'd0);
    chk("w0_idle_gap_busy", 32'(busy_v[1]), 32'd0);
    @(posedge clk); #1;
    chk("w0_ack_second", 32'(ack_v[1]), 32'd1);
    req_v[1] = 1'b0;
    @(posedge clk); #1;
    chk("w0_ack_done", 32'(ack_v[1]), 32'd0);

    // Bus changes during WAIT are ignored.
    xact(0, 1'b1, 32'd5, 32'hCAFEF00D, 1'b1);
    xact(0, 1'b0, 32'd5, 32'h0, 1'b0);
    xact(0, 1'b0, 32'd9, 32'h0, 1'b0);
    chk("word9_unchanged", rdata_v[0], 32'h9999_9999);

    // Reset in the first WAIT cycle discards the pending store.
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'd7; wdata_v[0] = 32'h0000_1234;
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack_v[0]), 32'd0);
    chk("midrst_busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (5) @(negedge clk);
    chk("midrst_idle_busy", 32'(busy_v[0]), 32'd0);
    xact(0, 1'b0, 32'd7, 32'h0, 1'b0);
    chk("word7_pretest", rdata_v[0], 32'h7777_7777);

    // Out-of-range store, then read word 3 and the out-of-range address.
    xact(0, 1'b1, 32'd259, 32'h0000_A5A5, 1'b0);
    xact(0, 1'b0, 32'd3, 32'h0, 1'b0);
    chk("word3_after_oor", rdata_v[0], ERR_MODE ? 32'h3333_3333 : 32'h0000_A5A5);
    xact(0, 1'b0, 32'd259, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end
endmodule
